john_ring_seq_monitor: RTL and testbench
========================================

Name: john_ring_seq_monitor

Overview:
Downstream checker for the 4-bit Johnson/ring counter pair. It samples both counter outputs and their enable strobes every cycle and decodes each code to a phase index. It predicts each next code, tracks lock per channel, and flags illegal codes or wrong transitions. Its outputs drive status logic and coverage in the counter subsystem.

Parameters:
LOCK_CNT, 4, consecutive correct samples needed to declare lock (range 2..15)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en1  input  1  Johnson counter advance enable (same net as counter's en1)
en2  input  1  ring counter advance enable (same net as counter's en2)
qin1  input  4  Johnson counter output
qin2  input  4  ring counter output
clr_err  input  1  synchronous clear of sticky errors and error count
phase1  output  3  decoded Johnson phase 0..7
phase2  output  2  decoded ring phase 0..3
legal1  output  1  qin1 was a legal Johnson code
legal2  output  1  qin2 was a legal one-hot code
lock1  output  1  channel 1 in LOCK
lock2  output  1  channel 2 in LOCK
err1  output  1  channel 1 sticky error
err2  output  1  channel 2 sticky error
wrap1  output  1  one-cycle pulse on a valid Johnson 7->0 advance
wrap2  output  1  one-cycle pulse on a valid ring 3->0 advance
err_cnt  output  ERR_W  saturating count of LOCK->ERR entries

Behaviour:
- Reset (async, rst=1): all outputs 0, both FSMs in IDLE, history registers cleared.
- Upstream sequences (fixed): Johnson 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000, phases 0..7. Ring 0001,0010,0100,1000, then back to 0001, phase = set-bit index. The upstream counters reset to 0000 and 0001.
- Sampling: qin and en are registered at every posedge. Expected sample k = en[k-1] ? next(q[k-1]) : q[k-1]. "good" means the sample is legal and equals the expected value.
- Decode outputs are registered, 1-cycle latency from sample. An illegal code gives phase=0 and legal=0.
- Per-channel FSM, evaluated every cycle:
  - IDLE -> TRACK on a legal sample; good counter set to 0.
  - TRACK, good sample: good counter increments; at LOCK_CNT-1 -> LOCK.
  - TRACK, legal but not good: stay in TRACK, good counter reset to 0.
  - TRACK, illegal sample: -> IDLE.
  - LOCK, good sample: stay in LOCK.
  - LOCK, not good (illegal or mismatch): -> ERR, err set, error event counted.
  - ERR: stays in ERR regardless of input; only clr_err or rst leaves it.
- clr_err has priority over every transition in the same cycle. It forces both FSMs to IDLE, clears err1/err2, and sets err_cnt to 0. An error coinciding with clr_err is dropped.
- lockN = (state==LOCK), registered.
- wrapN pulses for 1 cycle when a good sample is an advance from the last phase to phase 0 in TRACK or LOCK.
- err_cnt adds 0, 1 or 2 per cycle; both channels entering ERR in one cycle adds 2. It saturates at 2^ERR_W-1 and never wraps.
- No advance is assumed without en. A hold with en=0 counts as good if the code is unchanged.
- When rst asserts mid-operation, every output is 0 from that edge onward. The monitor resumes at IDLE after release.

Decomposition:
- Package john_ring_pkg holds:
  - the state enum (IDLE, TRACK, LOCK, ERR)
  - Johnson and ring code constants
  - johnson_next and ring_next functions
  - johnson_decode and ring_decode functions returning phase plus legal
- Sub-module seq_chan_checker (params MODE = JOHNSON|RING, LOCK_CNT) holds one FSM, history, decode and wrap logic. It is instantiated twice.
- The top holds err_cnt and the clr_err fan-out.

Test Plan:
- Reset: assert rst mid-cycle with counters running -> all outputs 0 immediately. After release and 1 sample of 0000/0001, phase1=0, phase2=0, legal=1, lock=0.
- Lock and wrap: drive the counter with en1=1 for 10 cycles -> lock1 rises 1 cycle after the LOCK_CNT-th sample. Phase1 steps 0..7,0. wrap1 pulses exactly once on 1000->0000.
- Hold: after lock, en1=en2=0 for 5 cycles with codes unchanged -> lock stays 1, err=0.
- Illegal code: while locked, force qin1=0101 for 1 cycle -> legal1=0, err1=1 sticky, lock1=0, err_cnt=1.
- Mismatch on ring and simultaneous errors: with both locked and en2=0, force qin2 to skip 0010->1000 and qin1 to an illegal code in the same cycle -> err1=err2=1, err_cnt increases by 2.
- Clear priority and saturation: with ERR_W=2, produce 5 lock-then-error cycles -> err_cnt holds at 3. Then assert clr_err coincident with a new error -> err_cnt=0, err=0, both FSMs in IDLE.

Source files
------------

// File: rtl/john_ring_pkg.sv
// Shared definitions for the Johnson/ring sequence monitor.
//   chan_state_e : per-channel checker state (IDLE, TRACK, LOCK, ERR)
//   chan_mode_e  : selects which code family a checker instance follows
//   JOHN_Cn/RING_Cn : legal codes in sequence order (index = phase)
//   johnson_next/ring_next     : successor code of a legal code
//   johnson_decode/ring_decode : phase index plus legality of a raw code
package john_ring_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2,
    ERR   = 2'd3
  } chan_state_e;

  typedef enum logic {
    JOHNSON = 1'b0,
    RING    = 1'b1
  } chan_mode_e;

  localparam logic [3:0] JOHN_C0 = 4'b0000;
  localparam logic [3:0] JOHN_C1 = 4'b0001;
  localparam logic [3:0] JOHN_C2 = 4'b0011;
  localparam logic [3:0] JOHN_C3 = 4'b0111;
  localparam logic [3:0] JOHN_C4 = 4'b1111;
  localparam logic [3:0] JOHN_C5 = 4'b1110;
  localparam logic [3:0] JOHN_C6 = 4'b1100;
  localparam logic [3:0] JOHN_C7 = 4'b1000;

  localparam logic [3:0] RING_C0 = 4'b0001;
  localparam logic [3:0] RING_C1 = 4'b0010;
  localparam logic [3:0] RING_C2 = 4'b0100;
  localparam logic [3:0] RING_C3 = 4'b1000;

  typedef struct packed {
    logic [2:0] phase;
    logic       legal;
  } john_dec_t;

  typedef struct packed {
    logic [1:0] phase;
    logic       legal;
  } ring_dec_t;

  // Twisted-ring shift: inverted MSB feeds the LSB.
  function automatic logic [3:0] johnson_next(input logic [3:0] q);
    return {q[2:0], ~q[3]};
  endfunction

  // Plain rotate left of the one-hot token.
  function automatic logic [3:0] ring_next(input logic [3:0] q);
    return {q[2:0], q[3]};
  endfunction

  // Illegal codes decode to phase 0 with legal cleared.
  function automatic john_dec_t johnson_decode(input logic [3:0] q);
    john_dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (q)
      JOHN_C0: d.phase = 3'd0;
      JOHN_C1: d.phase = 3'd1;
      JOHN_C2: d.phase = 3'd2;
      JOHN_C3: d.phase = 3'd3;
      JOHN_C4: d.phase = 3'd4;
      JOHN_C5: d.phase = 3'd5;
      JOHN_C6: d.phase = 3'd6;
      JOHN_C7: d.phase = 3'd7;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic ring_dec_t ring_decode(input logic [3:0] q);
    ring_dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (q)
      RING_C0: d.phase = 2'd0;
      RING_C1: d.phase = 2'd1;
      RING_C2: d.phase = 2'd2;
      RING_C3: d.phase = 2'd3;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/john_ring_seq_monitor_chan.sv
// seq_chan_checker: one monitor channel for either a Johnson or a ring code.
//   clk, rst  : clock, asynchronous active-high reset
//   en, qin   : counter advance enable and counter output, sampled every edge
//   clr_err   : synchronous clear; forces IDLE and drops the sticky error
//   phase     : decoded phase of the previous sample (0 when illegal)
//   legal     : previous sample was a legal code
//   lock      : channel is in LOCK
//   err       : sticky error, set on leaving LOCK through a bad sample
//   wrap      : pulse on a good last-phase -> phase-0 advance
//   err_evt   : combinational strobe, high in the cycle the LOCK->ERR entry is taken
import john_ring_pkg::*;

module seq_chan_checker #(
  parameter chan_mode_e MODE     = JOHNSON,
  parameter int         LOCK_CNT = 4,
  localparam int        PH_W     = (MODE == JOHNSON) ? 3 : 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3:0]      qin,
  input  logic            clr_err,
  output logic [PH_W-1:0] phase,
  output logic            legal,
  output logic            lock,
  output logic            err,
  output logic            wrap,
  output logic            err_evt
);

  chan_state_e     state, state_nxt;
  logic [3:0]      gcnt, gcnt_nxt;

  logic [3:0]      q_p0, q_p1;
  logic            en_p0, en_p1;
  logic            vld_p0;

  logic [3:0]      q_exp;
  logic [PH_W-1:0] phase_s;
  logic            legal_s;
  logic            last_s;
  logic            good;

  logic            lock_nxt, err_nxt, wrap_nxt;

  // Stage p0: raw sample; p1: the sample before it, used to predict p0.
  // vld_p0 masks the reset value of q_p0 until a real sample has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_p0   <= '0;
      en_p0  <= 1'b0;
      q_p1   <= '0;
      en_p1  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      q_p0   <= qin;
      en_p0  <= en;
      q_p1   <= q_p0;
      en_p1  <= en_p0;
      vld_p0 <= 1'b1;
    end
  end

  generate
    if (MODE == JOHNSON) begin : g_john
      john_dec_t dec;
      always_comb begin
        dec     = johnson_decode(q_p0);
        phase_s = dec.phase;
        legal_s = dec.legal;
        q_exp   = en_p1 ? johnson_next(q_p1) : q_p1;
        last_s  = en_p1 && (q_p1 == JOHN_C7);
      end
    end else begin : g_ring
      ring_dec_t dec;
      always_comb begin
        dec     = ring_decode(q_p0);
        phase_s = dec.phase;
        legal_s = dec.legal;
        q_exp   = en_p1 ? ring_next(q_p1) : q_p1;
        last_s  = en_p1 && (q_p1 == RING_C3);
      end
    end
  endgenerate

  assign good = vld_p0 && legal_s && (q_p0 == q_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
    end else begin
      state <= state_nxt;
      gcnt  <= gcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    if (clr_err) begin
      state_nxt = IDLE;
      gcnt_nxt  = '0;
    end else if (vld_p0) begin
      case (state)
        IDLE: begin
          if (legal_s) begin
            state_nxt = TRACK;
            gcnt_nxt  = '0;
          end
        end
        TRACK: begin
          if (!legal_s) begin
            state_nxt = IDLE;
          end else if (good) begin
            // The incremented count reaching LOCK_CNT-1 marks the
            // LOCK_CNT-th consecutive legal sample since leaving IDLE.
            gcnt_nxt = gcnt + 4'd1;
            if (gcnt == 4'(LOCK_CNT - 2)) begin
              state_nxt = LOCK;
            end
          end else begin
            gcnt_nxt = '0;
          end
        end
        LOCK: begin
          if (!good) begin
            state_nxt = ERR;
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err_evt  = !clr_err && vld_p0 && (state == LOCK) && !good;
    lock_nxt = (state_nxt == LOCK);
    err_nxt  = clr_err ? 1'b0 : (err | err_evt);
    wrap_nxt = good && last_s && ((state == TRACK) || (state == LOCK));
  end

  // Stage p1 outputs: decode and status of the p0 sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      legal <= 1'b0;
      lock  <= 1'b0;
      err   <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      phase <= vld_p0 ? phase_s : '0;
      legal <= vld_p0 && legal_s;
      lock  <= lock_nxt;
      err   <= err_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: rtl/john_ring_seq_monitor.sv
// john_ring_seq_monitor: checker for the 4-bit Johnson/ring counter pair.
//   clk, rst       : clock, asynchronous active-high reset
//   en1, qin1      : Johnson counter enable and output
//   en2, qin2      : ring counter enable and output
//   clr_err        : synchronous clear of both channels and the error count
//   phase1/phase2  : decoded phases (1-cycle latency from sample)
//   legal1/legal2  : sample legality
//   lock1/lock2    : channel in LOCK
//   err1/err2      : sticky channel errors
//   wrap1/wrap2    : pulse on a good last-phase -> phase-0 advance
//   err_cnt        : saturating count of LOCK->ERR entries
import john_ring_pkg::*;

module john_ring_seq_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic [3:0]       qin1,
  input  logic [3:0]       qin2,
  input  logic             clr_err,
  output logic [2:0]       phase1,
  output logic [1:0]       phase2,
  output logic             legal1,
  output logic             legal2,
  output logic             lock1,
  output logic             lock2,
  output logic             err1,
  output logic             err2,
  output logic             wrap1,
  output logic             wrap2,
  output logic [ERR_W-1:0] err_cnt
);

  logic           evt1, evt2;
  logic [ERR_W:0] cnt_sum;

  seq_chan_checker #(
    .MODE     (JOHNSON),
    .LOCK_CNT (LOCK_CNT)
  ) u_chan1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en1),
    .qin     (qin1),
    .clr_err (clr_err),
    .phase   (phase1),
    .legal   (legal1),
    .lock    (lock1),
    .err     (err1),
    .wrap    (wrap1),
    .err_evt (evt1)
  );

  seq_chan_checker #(
    .MODE     (RING),
    .LOCK_CNT (LOCK_CNT)
  ) u_chan2 (
    .clk     (clk),
    .rst     (rst),
    .en      (en2),
    .qin     (qin2),
    .clr_err (clr_err),
    .phase   (phase2),
    .legal   (legal2),
    .lock    (lock2),
    .err     (err2),
    .wrap    (wrap2),
    .err_evt (evt2)
  );

  // One extra bit catches the carry so the count clamps instead of wrapping.
  always_comb begin
    cnt_sum = {1'b0, err_cnt} + {{ERR_W{1'b0}}, evt1} + {{ERR_W{1'b0}}, evt2};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= cnt_sum[ERR_W] ? '1 : cnt_sum[ERR_W-1:0];
    end
  end

endmodule

// File: tb/tb_john_ring_seq_monitor.sv
module tb_john_ring_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en1 = 1'b0;
  logic       en2 = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] qin1 = 4'b0000;
  logic [3:0] qin2 = 4'b0001;

  logic [2:0] phase1, s_phase1;
  logic [1:0] phase2, s_phase2;
  logic       legal1, legal2, lock1, lock2, err1, err2, wrap1, wrap2;
  logic       s_legal1, s_legal2, s_lock1, s_lock2, s_err1, s_err2, s_wrap1, s_wrap2;
  logic [7:0] err_cnt;
  logic [0:0] s_err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] j_q, r_q;

  always #5 clk = ~clk;

  john_ring_seq_monitor #(.LOCK_CNT(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en1(en1), .en2(en2), .qin1(qin1), .qin2(qin2),
    .clr_err(clr_err), .phase1(phase1), .phase2(phase2), .legal1(legal1),
    .legal2(legal2), .lock1(lock1), .lock2(lock2), .err1(err1), .err2(err2),
    .wrap1(wrap1), .wrap2(wrap2), .err_cnt(err_cnt)
  );

  // Narrow error counter instance to exercise saturation.
  john_ring_seq_monitor #(.LOCK_CNT(4), .ERR_W(1)) dut_sat (
    .clk(clk), .rst(rst), .en1(en1), .en2(en2), .qin1(qin1), .qin2(qin2),
    .clr_err(clr_err), .phase1(s_phase1), .phase2(s_phase2), .legal1(s_legal1),
    .legal2(s_legal2), .lock1(s_lock1), .lock2(s_lock2), .err1(s_err1), .err2(s_err2),
    .wrap1(s_wrap1), .wrap2(s_wrap2), .err_cnt(s_err_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] jn(input logic [3:0] q);
    case (q)
      4'b0000: return 4'b0001;
      4'b0001: return 4'b0011;
      4'b0011: return 4'b0111;
      4'b0111: return 4'b1111;
      4'b1111: return 4'b1110;
      4'b1110: return 4'b1100;
      4'b1100: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] rn(input logic [3:0] q);
    case (q)
      4'b0001: return 4'b0010;
      4'b0010: return 4'b0100;
      4'b0100: return 4'b1000;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic drive(input logic [3:0] q1, input logic e1, input logic [3:0] q2,
                       input logic e2, input logic c);
    qin1 = q1; en1 = e1; qin2 = q2; en2 = e2; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  // Drive the modelled counter codes, then advance the model as the counters would.
  task automatic tick(input logic e1, input logic e2, input logic c);
    drive(j_q, e1, r_q, e2, c);
    if (e1) j_q = jn(j_q);
    if (e2) r_q = rn(r_q);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_main"}, 32'({phase1, phase2, legal1, legal2, lock1, lock2,
                                   err1, err2, wrap1, wrap2, err_cnt}), 32'd0);
    check_val({tag, "_sat"}, 32'({s_phase1, s_phase2, s_legal1, s_legal2, s_lock1, s_lock2,
                                  s_err1, s_err2, s_wrap1, s_wrap2, s_err_cnt}), 32'd0);
  endtask

  initial begin
    j_q = 4'b0000;
    r_q = 4'b0001;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Lock and wrap, both counters running
    for (int t = 1; t <= 11; t++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (t >= 2) begin
        check_val($sformatf("ph1_t%0d", t), 32'(phase1), 32'((t - 2) % 8));
        check_val($sformatf("ph2_t%0d", t), 32'(phase2), 32'((t - 2) % 4));
        check_val($sformatf("legal_t%0d", t), 32'({legal1, legal2}), 32'h3);
        check_val($sformatf("lock1_t%0d", t), 32'(lock1), 32'(t >= 5));
        check_val($sformatf("lock2_t%0d", t), 32'(lock2), 32'(t >= 5));
        check_val($sformatf("wrap1_t%0d", t), 32'(wrap1), 32'(t == 10));
        check_val($sformatf("wrap2_t%0d", t), 32'(wrap2), 32'(t == 6 || t == 10));
      end
    end

    // Hold with enables low
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    check_val("hold_lock", 32'({lock1, lock2}), 32'h3);
    check_val("hold_err", 32'({err1, err2}), 32'h0);
    check_val("hold_ph1", 32'(phase1), 32'd3);
    check_val("hold_ph2", 32'(phase2), 32'd3);

    // Illegal Johnson code while locked
    drive(4'b0101, 1'b0, r_q, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("ill_legal1", 32'(legal1), 32'd0);
    check_val("ill_ph1", 32'(phase1), 32'd0);
    check_val("ill_err1", 32'(err1), 32'd1);
    check_val("ill_lock1", 32'(lock1), 32'd0);
    check_val("ill_errcnt", 32'(err_cnt), 32'd1);
    check_val("ill_errcnt_sat", 32'(s_err_cnt), 32'd1);
    check_val("ill_ch2", 32'({lock2, err2}), 32'h2);
    tick(1'b0, 1'b0, 1'b0);
    check_val("sticky_err1", 32'(err1), 32'd1);
    check_val("sticky_lock1", 32'(lock1), 32'd0);
    check_val("sticky_legal1", 32'(legal1), 32'd1);

    // Clear, relock, then simultaneous errors
    tick(1'b1, 1'b1, 1'b1);
    check_val("clr_err", 32'({err1, err2}), 32'h0);
    check_val("clr_errcnt", 32'(err_cnt), 32'd0);
    check_val("clr_lock", 32'({lock1, lock2}), 32'h0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0);
    check_val("relock", 32'({lock1, lock2}), 32'h3);
    for (int i = 0; i < 4 && r_q != 4'b0010; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    drive(4'b0101, 1'b0, 4'b1000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_val("dual_err", 32'({err1, err2}), 32'h3);
    check_val("dual_errcnt", 32'(err_cnt), 32'd2);
    check_val("dual_errcnt_sat", 32'(s_err_cnt), 32'd1);
    check_val("dual_lock", 32'({lock1, lock2}), 32'h0);
    check_val("dual_legal", 32'({legal1, legal2}), 32'h1);
    check_val("dual_ph2", 32'(phase2), 32'd3);

    // Clear coinciding with a new error
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0);
    check_val("relock2", 32'({lock1, lock2}), 32'h3);
    drive(4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check_val("clrpri_err", 32'({err1, err2}), 32'h0);
    check_val("clrpri_errcnt", 32'(err_cnt), 32'd0);
    check_val("clrpri_errcnt_sat", 32'(s_err_cnt), 32'd0);
    check_val("clrpri_lock", 32'({lock1, lock2}), 32'h0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    check_val("idle_relock", 32'({lock1, lock2, err1, err2}), 32'hC);

    // Asynchronous reset mid-cycle with counters running
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    check_all_zero("held_rst");
    rst = 1'b0;
    j_q = 4'b0000;
    r_q = 4'b0001;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check_val("post_rst_ph", 32'({phase1, phase2}), 32'd0);
    check_val("post_rst_legal", 32'({legal1, legal2}), 32'h3);
    check_val("post_rst_lock", 32'({lock1, lock2}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
